// File: rtl/ibex_counter_bank.sv
// Bank of NumCounters performance counters, each with its own event mask,
// inhibit, split 32-bit CSR write access and sticky overflow flag.
module ibex_counter_bank #(
  parameter int unsigned NumCounters  = 4,
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16,
  parameter int unsigned IdxW         = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumEvents-1:0]   event_i,
  input  logic [NumCounters-1:0] inhibit_i,
  input  logic [IdxW-1:0]        wr_idx_i,
  input  logic                   wr_lo_we_i,
  input  logic                   wr_hi_we_i,
  input  logic                   wr_cfg_we_i,
  input  logic [31:0]            wr_data_i,
  input  logic [NumCounters-1:0] ovf_clr_i,
  input  logic [IdxW-1:0]        rd_idx_i,
  output logic [63:0]            rd_val_o,
  output logic [31:0]            rd_cfg_o,
  output logic [NumCounters-1:0] ovf_o,
  output logic                   any_ovf_o
);

  // A counter of 32 bits or fewer has no high half, so a high write is a no-op there.
  localparam bit HasHi = (CounterWidth > 32);

  logic                    w_hi_eff;
  logic [CounterWidth-1:0] w_cnt  [NumCounters];
  logic [NumEvents-1:0]    w_mask [NumCounters];
  logic [NumCounters-1:0]  w_ovf;

  assign w_hi_eff = wr_hi_we_i & HasHi;

  for (genvar gi = 0; gi < NumCounters; gi++) begin : g_ch
    logic [CounterWidth-1:0] r_cnt;
    logic [CounterWidth-1:0] w_cnt_d;
    logic [NumEvents-1:0]    r_mask;
    logic                    r_ovf;
    logic                    w_ovf_d;
    logic                    w_sel;
    logic                    w_load;
    logic                    w_inc;
    logic                    w_wrap;
    logic [63:0]             w_cur;
    logic [31:0]             w_lo;
    logic [31:0]             w_hi;

    // Out-of-range write indices never match any channel, so they are dropped.
    assign w_sel  = (wr_idx_i == IdxW'(gi));
    assign w_load = w_sel & (wr_lo_we_i | w_hi_eff);
    // Any number of matching events in one cycle counts as a single increment.
    assign w_inc  = (|(r_mask & event_i)) & ~inhibit_i[gi];
    assign w_wrap = w_inc & (&r_cnt);

    // Merge the written half with the retained half; both enables load {data, data}.
    assign w_cur = 64'(r_cnt);
    assign w_lo  = wr_lo_we_i ? wr_data_i : w_cur[31:0];
    assign w_hi  = w_hi_eff   ? wr_data_i : w_cur[63:32];

    // Next count and flag: a CSR write wins over counting and clears the flag,
    // a wrap sets the flag and wins over a clear pulse.
    always_comb begin
      w_cnt_d = r_cnt;
      w_ovf_d = r_ovf;
      if (w_load) begin
        w_cnt_d = CounterWidth'({w_hi, w_lo});
        w_ovf_d = 1'b0;
      end else begin
        if (w_inc) begin
          w_cnt_d = r_cnt + CounterWidth'(1);
        end
        if (w_wrap) begin
          w_ovf_d = 1'b1;
        end else if (ovf_clr_i[gi]) begin
          w_ovf_d = 1'b0;
        end
      end
    end

    // Channel state; the mask write is independent of the counter write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt  <= '0;
        r_mask <= '0;
        r_ovf  <= 1'b0;
      end else begin
        r_cnt <= w_cnt_d;
        r_ovf <= w_ovf_d;
        if (w_sel && wr_cfg_we_i) begin
          r_mask <= wr_data_i[NumEvents-1:0];
        end
      end
    end

    assign w_cnt[gi]  = r_cnt;
    assign w_mask[gi] = r_mask;
    assign w_ovf[gi]  = r_ovf;
  end

  // Read mux straight from state; out-of-range indices read as zero.
  always_comb begin
    rd_val_o = '0;
    rd_cfg_o = '0;
    for (int unsigned i = 0; i < NumCounters; i++) begin
      if (rd_idx_i == IdxW'(i)) begin
        rd_val_o = 64'(w_cnt[i]);
        rd_cfg_o = 32'(w_mask[i]);
      end
    end
  end

  assign ovf_o     = w_ovf;
  assign any_ovf_o = |w_ovf;

endmodule

// File: tb/tb_ibex_counter_bank.sv
// Scoreboard bench for ibex_counter_bank: the driver pushes hand-computed expectations,
// a monitor selects the read index and checks them away from the clock edge.
module tb_ibex_counter_bank;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [15:0] event_i;
  logic [3:0]  inhibit_i;
  logic [4:0]  wr_idx_i;
  logic        wr_lo_we_i;
  logic        wr_hi_we_i;
  logic        wr_cfg_we_i;
  logic [31:0] wr_data_i;
  logic [3:0]  ovf_clr_i;
  logic [4:0]  rd_idx_i;
  logic [63:0] rd_val_o;
  logic [31:0] rd_cfg_o;
  logic [3:0]  ovf_o;
  logic        any_ovf_o;

  ibex_counter_bank #(
    .NumCounters (4),
    .CounterWidth(40),
    .NumEvents   (16),
    .IdxW        (5)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .event_i    (event_i),
    .inhibit_i  (inhibit_i),
    .wr_idx_i   (wr_idx_i),
    .wr_lo_we_i (wr_lo_we_i),
    .wr_hi_we_i (wr_hi_we_i),
    .wr_cfg_we_i(wr_cfg_we_i),
    .wr_data_i  (wr_data_i),
    .ovf_clr_i  (ovf_clr_i),
    .rd_idx_i   (rd_idx_i),
    .rd_val_o   (rd_val_o),
    .rd_cfg_o   (rd_cfg_o),
    .ovf_o      (ovf_o),
    .any_ovf_o  (any_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    int          due;
    logic [4:0]  idx;
    logic [63:0] val;
    logic [31:0] cfg;
    logic [3:0]  ovf;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string nm, input string fld, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h, want %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: selects the read channel for the due entry, compares on the falling edge.
  initial begin
    exp_t e;
    rd_idx_i = '0;
    forever begin
      @(posedge clk_i);
      #2;
      if (q.size() > 0 && q[0].due == cyc) rd_idx_i = q[0].idx;
      @(negedge clk_i);
      while (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL %s: entry never sampled, due %0d now %0d", e.name, e.due, cyc);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check(e.name, "rd_val", rd_val_o, e.val);
        check(e.name, "rd_cfg", 64'(rd_cfg_o), 64'(e.cfg));
        check(e.name, "ovf", 64'(ovf_o), 64'(e.ovf));
        check(e.name, "any_ovf", 64'(any_ovf_o), 64'(|e.ovf));
      end
    end
  end

  task automatic expect_now(input string nm, input int idx, input logic [63:0] v,
                            input logic [31:0] c, input logic [3:0] o);
    exp_t e;
    e.name = nm;
    e.due  = cyc;
    e.idx  = 5'(idx);
    e.val  = v;
    e.cfg  = c;
    e.ovf  = o;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input int idx, input bit lo, input bit hi, input bit cfg,
                    input logic [31:0] data);
    wr_idx_i    = 5'(idx);
    wr_lo_we_i  = lo;
    wr_hi_we_i  = hi;
    wr_cfg_we_i = cfg;
    wr_data_i   = data;
    step();
    wr_lo_we_i  = 1'b0;
    wr_hi_we_i  = 1'b0;
    wr_cfg_we_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Driver.
  initial begin
    rst_ni      = 1'b0;
    event_i     = '0;
    inhibit_i   = '0;
    wr_idx_i    = '0;
    wr_lo_we_i  = 1'b0;
    wr_hi_we_i  = 1'b0;
    wr_cfg_we_i = 1'b0;
    wr_data_i   = '0;
    ovf_clr_i   = '0;
    step();
    expect_now("rst_ch0", 0, 64'h0, 32'h0, 4'h0);
    step();
    expect_now("rst_ch3", 3, 64'h0, 32'h0, 4'h0);
    rst_ni = 1'b1;
    step();

    // Mask write with a matching event in the same cycle: old (zero) mask applies.
    event_i = 16'h0001;
    wr(0, 0, 0, 1, 32'h0000_0001);
    expect_now("cfg_ch0", 0, 64'h0, 32'h1, 4'h0);
    repeat (5) step();
    event_i = '0;
    expect_now("count5", 0, 64'h5, 32'h1, 4'h0);
    step();

    // Wrap on channel 1.
    wr(1, 1, 0, 0, 32'hFFFF_FFFF);
    wr(1, 0, 1, 0, 32'h0000_00FF);
    wr(1, 0, 0, 1, 32'h0000_0001);
    expect_now("load_ch1", 1, 64'hFF_FFFF_FFFF, 32'h1, 4'h0);
    event_i = 16'h0001;
    step();
    event_i = '0;
    expect_now("wrap_ch1", 1, 64'h0, 32'h1, 4'b0010);
    step();
    ovf_clr_i = 4'b0010;
    step();
    ovf_clr_i = '0;
    expect_now("clr_ch1", 1, 64'h0, 32'h1, 4'h0);
    step();

    // Both halves at once load {data, data}; then wrap together with a clear pulse.
    wr(1, 1, 1, 0, 32'hFFFF_FFFF);
    expect_now("both_ch1", 1, 64'hFF_FFFF_FFFF, 32'h1, 4'h0);
    event_i   = 16'h0001;
    ovf_clr_i = 4'b0010;
    step();
    event_i   = '0;
    ovf_clr_i = '0;
    expect_now("set_wins", 1, 64'h0, 32'h1, 4'b0010);
    wr(1, 1, 0, 0, 32'h0000_0003);
    expect_now("wr_clears", 1, 64'h3, 32'h1, 4'h0);
    step();

    // Write beats a same-cycle increment.
    wr(2, 0, 0, 1, 32'h0000_0001);
    event_i = 16'h0001;
    wr(2, 1, 0, 0, 32'h0000_0010);
    expect_now("prio_wr", 2, 64'h10, 32'h1, 4'h0);
    step();
    event_i = '0;
    expect_now("prio_inc", 2, 64'h11, 32'h1, 4'h0);
    step();

    // High-half write keeps the low half and truncates to 40 bits.
    wr(3, 1, 0, 0, 32'h0000_0005);
    wr(3, 0, 1, 0, 32'hABCD_1234);
    expect_now("hi_ch3", 3, 64'h0000_0034_0000_0005, 32'h0, 4'h0);
    step();

    // Two matching events per cycle still add one.
    wr(3, 0, 0, 1, 32'h0000_0006);
    event_i = 16'h0006;
    repeat (3) step();
    event_i = '0;
    expect_now("or_events", 3, 64'h0000_0034_0000_0008, 32'h6, 4'h0);
    step();
    inhibit_i = 4'b1000;
    event_i   = 16'h0006;
    repeat (3) step();
    event_i   = '0;
    inhibit_i = '0;
    expect_now("inhibit", 3, 64'h0000_0034_0000_0008, 32'h6, 4'h0);
    step();

    // Out-of-range write touches nothing; out-of-range read is zero.
    wr(4, 1, 1, 1, 32'hDEAD_BEEF);
    expect_now("oor_rd", 4, 64'h0, 32'h0, 4'h0);
    step();
    expect_now("oor_ch0", 0, 64'h9, 32'h1, 4'h0);
    step();
    expect_now("oor_ch1", 1, 64'h5, 32'h1, 4'h0);
    step();
    expect_now("oor_ch2", 2, 64'h11, 32'h1, 4'h0);
    step();
    expect_now("oor_ch3", 3, 64'h0000_0034_0000_0008, 32'h6, 4'h0);
    step();

    // Raise a flag, then assert reset between edges.
    wr(1, 1, 1, 0, 32'hFFFF_FFFF);
    event_i = 16'h0001;
    step();
    event_i = '0;
    expect_now("pre_rst", 1, 64'h0, 32'h1, 4'b0010);
    step();
    expect_now("async_rst", 0, 64'h0, 32'h0, 4'h0);
    rst_ni = 1'b0;
    step();
    expect_now("rst_cfg2", 2, 64'h0, 32'h0, 4'h0);
    rst_ni = 1'b1;
    step();
    expect_now("rd_idx31", 31, 64'h0, 32'h0, 4'h0);
    step();

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk_i);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_counter_bank.md
# ibex_counter_bank

Parametrised bank of hardware performance counters for the core's CSR unit, generalising the single-counter block to `NumCounters` independent channels. Each channel has:
- a configurable event-select mask,
- a per-channel inhibit,
- 32-bit low/high half CSR write access,
- a sticky overflow flag.

It sits beside the CSR file. The CSR decoder drives the write/read index; pipeline and LSU event strobes drive `event_i`.

## Interface
- `NumCounters`, default 4: number of counter channels, 1..29.
- `CounterWidth`, default 40: implemented bits per counter, 1..64. Bits above it read as zero.
- `NumEvents`, default 16: number of event inputs, 1..32.
- `IdxW`, default 5: index width. It must satisfy 2^IdxW >= `NumCounters`.

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `event_i`  in  `NumEvents`  event strobes, sampled every cycle.
- `inhibit_i`  in  `NumCounters`  per-channel count inhibit (mcountinhibit).
- `wr_idx_i`  in  `IdxW`  target channel for writes.
- `wr_lo_we_i`  in  1  write `wr_data_i` to counter bits [31:0].
- `wr_hi_we_i`  in  1  write `wr_data_i` to counter bits [63:32].
- `wr_cfg_we_i`  in  1  write `wr_data_i[NumEvents-1:0]` to the channel event mask.
- `wr_data_i`  in  32  write data.
- `ovf_clr_i`  in  `NumCounters`  per-channel overflow flag clear pulse.
- `rd_idx_i`  in  `IdxW`  read channel select.
- `rd_val_o`  out  64  counter value of `rd_idx_i`, zero-extended; combinational from state.
- `rd_cfg_o`  out  32  event mask of `rd_idx_i`, zero-extended.
- `ovf_o`  out  `NumCounters`  sticky overflow flags.
- `any_ovf_o`  out  1  OR of `ovf_o`.

## Operation
- **Counting.** Channel i increments by 1 in a cycle when both conditions hold:
  - `(mask[i] & event_i) != 0`;
  - `inhibit_i[i]` is 0.
  Multiple matching events in one cycle still add exactly 1.
- **Wrap-around.** Arithmetic is modulo 2^CounterWidth. An increment from all-ones wraps to 0 and sets `ovf[i]` in the same update.
- **Write targeting.** Writes apply only to channel `wr_idx_i`. If `wr_idx_i >= NumCounters`, the write is ignored with no side effect.
- **Low-half write.** `wr_lo_we_i` loads bits [31:0] and keeps bits [63:32].
- **High-half write.** `wr_hi_we_i` loads bits [63:32] and keeps bits [31:0].
- **Both halves in one cycle.** The counter loads `{wr_data_i, wr_data_i}`.
- **Width truncation.** Loaded bits at or above `CounterWidth` are discarded. A high-half write to a counter with `CounterWidth <= 32` has no effect.
- **Write priority.** A counter write (lo or hi) beats an increment in the same cycle. The written value is stored unincremented and no overflow is set.
- **Flag clear on write.** A counter write to channel i also clears `ovf[i]`.
- **Set beats clear.** When a wrap and `ovf_clr_i[i]` occur in the same cycle, the set wins and `ovf[i]` is 1.
- **Mask write.** `wr_cfg_we_i` updates the mask. The new mask governs counting from the next cycle; events in the write cycle use the old mask.
- **Independent writes.** `wr_cfg_we_i` and the counter write enables may assert together; both take effect.
- **Read.** If `rd_idx_i >= NumCounters`, `rd_val_o` and `rd_cfg_o` are 0.

## Timing
- **Reset (asynchronous):** all counters 0, all masks 0, all `ovf` 0. Therefore `rd_val_o`, `rd_cfg_o`, `ovf_o` and `any_ovf_o` are all 0 during and after reset.
- **Increment latency:** an event in cycle N makes the counter value N+1 visible on `rd_val_o` in cycle N+1.
- **Write latency:** a write in cycle N is visible on `rd_val_o`/`rd_cfg_o` in cycle N+1. There is no read-during-write bypass.
- **Overflow latency:** `ovf_o[i]` rises in the cycle after the wrapping increment. `any_ovf_o` follows combinationally.
- **No handshake:** every write completes in one cycle and the block has no stall path.
- **Reset mid-count:** an assertion of `rst_ni` at any time clears all state immediately. Counting resumes on the first clock edge after deassertion.

## Test plan
- **Reset and count:** after reset, set mask[0]=0x0001 and pulse `event_i[0]` for 5 cycles → `rd_val_o` (idx 0) = 5; `ovf_o` = 0.
- **Wrap, flag and clear:**
  - `CounterWidth`=40: write lo=0xFFFFFFFF and hi=0x000000FF to channel 1, then one matching event → value 0 and `ovf_o[1]`=1, `any_ovf_o`=1.
  - `ovf_clr_i[1]` pulse → flag 0.
- **Write priority:** with `event_i` matching every cycle, write lo=0x10 to channel 2 → next cycle 0x10, the cycle after 0x11.
- **High-half write:** a hi write to a 40-bit counter holding 0x5 with data 0xABCD1234 → `rd_val_o` = 0x0000003400000005.
- **Inhibit and OR-events:**
  - mask=0x0006 with `event_i`=0x0006 for 3 cycles → +3 (not +6).
  - `inhibit_i[3]`=1 with events matching → value unchanged.
- **Out-of-range and async reset:**
  - write to idx `NumCounters` → no channel changes.
  - read of idx `NumCounters` → 0.
  - asserting `rst_ni` between clock edges → all outputs 0 immediately.
